// File: rtl/spartan6_dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 slice model: opmode bit positions and
// the X/Z post-adder operand select encodings.
package spartan6_dsp48a1_pkg;

  localparam int OPMODE_W    = 8;
  localparam int OP_X_LSB    = 0;
  localparam int OP_Z_LSB    = 2;
  localparam int OP_PRE_SEL  = 4;
  localparam int OP_CARRY    = 5;
  localparam int OP_PRE_SUB  = 6;
  localparam int OP_POST_SUB = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'b00,
    X_M    = 2'b01,
    X_P    = 2'b10,
    X_DAB  = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'b00,
    Z_PCIN = 2'b01,
    Z_P    = 2'b10,
    Z_C    = 2'b11
  } z_sel_e;

endpackage

// File: rtl/spartan6_dsp48a1_stage_reg.sv
// One optional pipeline stage: clocked register with sync reset and clock
// enable when EN=1, a plain wire when EN=0.
module dsp_stage_reg #(
  parameter int WIDTH = 18,
  parameter int EN    = 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (EN == 1) begin : g_reg
      logic [WIDTH-1:0] r_q;

      // Reset wins over clock enable.
      always_ff @(posedge clk) begin
        if (i_rst) begin
          r_q <= '0;
        end else if (i_ce) begin
          r_q <= i_d;
        end
      end

      assign o_q = r_q;
    end else begin : g_bypass
      logic w_unused_ctrl;
      assign w_unused_ctrl = &{1'b0, clk, i_rst, i_ce};
      assign o_q = i_d;
    end
  endgenerate

endmodule

// File: rtl/spartan6_dsp48a1.sv
// Spartan-6 DSP48A1 slice: D+/-B pre-adder, 18x18 unsigned multiplier and
// 48-bit post-adder/subtracter with carry, every stage optionally registered.
module spartan6_dsp48a1
  import spartan6_dsp48a1_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic        clk,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTopmode,
  input  logic        RSTCARRYIN,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CECARRYIN,
  input  logic        CEopmode,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic        CARRYIN,
  input  logic [7:0]  opmode,
  input  logic [17:0] BCIN,
  input  logic [47:0] PCIN,
  output logic [17:0] BCOUT,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic [35:0] M,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);

  logic [OPMODE_W-1:0] w_op;
  logic [17:0] w_b_src;
  logic [17:0] w_b0;
  logic [17:0] w_d_r;
  logic [17:0] w_pre;
  logic [17:0] w_b1_in;
  logic [17:0] w_b1;
  logic [17:0] w_a0;
  logic [17:0] w_a1;
  logic [35:0] w_m_full;
  logic [35:0] w_m;
  logic [47:0] w_c_r;
  logic [47:0] w_x;
  logic [47:0] w_z;
  logic        w_cin_src;
  logic        w_cin;
  logic [48:0] w_x_cin;
  logic [48:0] w_post;
  logic [47:0] w_p;
  logic        w_cyo;
  logic        w_unused_inputs;

  // Inputs that a given B_INPUT / CARRYINSEL choice leaves unconnected.
  assign w_unused_inputs = &{1'b0, CARRYIN, BCIN, B};

  dsp_stage_reg #(.WIDTH(OPMODE_W), .EN(OPMODEREG)) u_op_reg (
    .clk(clk), .i_rst(RSTopmode), .i_ce(CEopmode), .i_d(opmode), .o_q(w_op)
  );

  generate
    if (B_INPUT == "DIRECT") begin : g_b_direct
      assign w_b_src = B;
    end else if (B_INPUT == "CASCADE") begin : g_b_cascade
      assign w_b_src = BCIN;
    end else begin : g_b_none
      assign w_b_src = '0;
    end

    if (CARRYINSEL == "OPMODE5") begin : g_cin_op
      assign w_cin_src = w_op[OP_CARRY];
    end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
      assign w_cin_src = CARRYIN;
    end else begin : g_cin_none
      assign w_cin_src = 1'b0;
    end
  endgenerate

  dsp_stage_reg #(.WIDTH(18), .EN(B0REG)) u_b0_reg (
    .clk(clk), .i_rst(RSTB), .i_ce(CEB), .i_d(w_b_src), .o_q(w_b0)
  );

  dsp_stage_reg #(.WIDTH(18), .EN(DREG)) u_d_reg (
    .clk(clk), .i_rst(RSTD), .i_ce(CED), .i_d(D), .o_q(w_d_r)
  );

  assign w_pre   = w_op[OP_PRE_SUB] ? (w_d_r - w_b0) : (w_d_r + w_b0);
  assign w_b1_in = w_op[OP_PRE_SEL] ? w_pre : w_b0;

  dsp_stage_reg #(.WIDTH(18), .EN(B1REG)) u_b1_reg (
    .clk(clk), .i_rst(RSTB), .i_ce(CEB), .i_d(w_b1_in), .o_q(w_b1)
  );

  dsp_stage_reg #(.WIDTH(18), .EN(A0REG)) u_a0_reg (
    .clk(clk), .i_rst(RSTA), .i_ce(CEA), .i_d(A), .o_q(w_a0)
  );

  dsp_stage_reg #(.WIDTH(18), .EN(A1REG)) u_a1_reg (
    .clk(clk), .i_rst(RSTA), .i_ce(CEA), .i_d(w_a0), .o_q(w_a1)
  );

  assign w_m_full = {18'd0, w_a1} * {18'd0, w_b1};

  dsp_stage_reg #(.WIDTH(36), .EN(MREG)) u_m_reg (
    .clk(clk), .i_rst(RSTM), .i_ce(CEM), .i_d(w_m_full), .o_q(w_m)
  );

  dsp_stage_reg #(.WIDTH(48), .EN(CREG)) u_c_reg (
    .clk(clk), .i_rst(RSTC), .i_ce(CEC), .i_d(C), .o_q(w_c_r)
  );

  always_comb begin
    w_x = '0;
    case (x_sel_e'(w_op[OP_X_LSB +: 2]))
      X_ZERO:  w_x = '0;
      X_M:     w_x = {12'd0, w_m};
      X_P:     w_x = w_p;
      X_DAB:   w_x = {w_d_r[11:0], w_a1, w_b1};
      default: w_x = '0;
    endcase
  end

  always_comb begin
    w_z = '0;
    case (z_sel_e'(w_op[OP_Z_LSB +: 2]))
      Z_ZERO:  w_z = '0;
      Z_PCIN:  w_z = PCIN;
      Z_P:     w_z = w_p;
      Z_C:     w_z = w_c_r;
      default: w_z = '0;
    endcase
  end

  dsp_stage_reg #(.WIDTH(1), .EN(CARRYINREG)) u_cyi_reg (
    .clk(clk), .i_rst(RSTCARRYIN), .i_ce(CECARRYIN), .i_d(w_cin_src), .o_q(w_cin)
  );

  // 49-bit arithmetic: bit 48 is the carry on add and the borrow on subtract.
  assign w_x_cin = {1'b0, w_x} + {48'd0, w_cin};
  assign w_post  = w_op[OP_POST_SUB] ? ({1'b0, w_z} - w_x_cin)
                                     : ({1'b0, w_z} + w_x_cin);

  dsp_stage_reg #(.WIDTH(48), .EN(PREG)) u_p_reg (
    .clk(clk), .i_rst(RSTP), .i_ce(CEP), .i_d(w_post[47:0]), .o_q(w_p)
  );

  dsp_stage_reg #(.WIDTH(1), .EN(CARRYOUTREG)) u_cyo_reg (
    .clk(clk), .i_rst(RSTCARRYIN), .i_ce(CECARRYIN), .i_d(w_post[48]), .o_q(w_cyo)
  );

  assign BCOUT     = w_b1;
  assign M         = w_m;
  assign P         = w_p;
  assign PCOUT     = w_p;
  assign CARRYOUT  = w_cyo;
  assign CARRYOUTF = w_cyo;

endmodule

// File: tb/tb_spartan6_dsp48a1.sv
// Self-checking bench for spartan6_dsp48a1 at default parameters; expected
// results are queued when stimulus is applied and compared on output.
module tb_spartan6_dsp48a1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RSTA, RSTB, RSTM, RSTP, RSTC, RSTD, RSTopmode, RSTCARRYIN;
  logic CEA, CEB, CEM, CEP, CEC, CED, CECARRYIN, CEopmode;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  opmode;
  logic [17:0] BCOUT;
  logic [47:0] P, PCOUT;
  logic [35:0] M;
  logic        CARRYOUT, CARRYOUTF;

  spartan6_dsp48a1 dut (
    .clk(clk),
    .RSTA(RSTA), .RSTB(RSTB), .RSTM(RSTM), .RSTP(RSTP), .RSTC(RSTC), .RSTD(RSTD),
    .RSTopmode(RSTopmode), .RSTCARRYIN(RSTCARRYIN),
    .CEA(CEA), .CEB(CEB), .CEM(CEM), .CEP(CEP), .CEC(CEC), .CED(CED),
    .CECARRYIN(CECARRYIN), .CEopmode(CEopmode),
    .A(A), .B(B), .D(D), .C(C), .CARRYIN(CARRYIN), .opmode(opmode),
    .BCIN(BCIN), .PCIN(PCIN),
    .BCOUT(BCOUT), .P(P), .PCOUT(PCOUT), .M(M),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  typedef struct {
    logic [17:0] bcout;
    logic [35:0] m;
    logic [47:0] p;
    logic        co;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rst(input logic v);
    RSTA = v; RSTB = v; RSTM = v; RSTP = v; RSTC = v; RSTD = v;
    RSTopmode = v; RSTCARRYIN = v;
  endtask

  task automatic set_ce(input logic v);
    CEA = v; CEB = v; CEM = v; CEP = v; CEC = v; CED = v;
    CECARRYIN = v; CEopmode = v;
  endtask

  function automatic exp_t model(input logic [7:0] op, input logic [17:0] a,
                                 input logic [17:0] b, input logic [17:0] d,
                                 input logic [47:0] c, input logic [47:0] pcin);
    exp_t e;
    logic [17:0] pre, b1;
    logic [47:0] x, z;
    logic [48:0] s;
    pre = op[6] ? (d - b) : (d + b);
    b1  = op[4] ? pre : b;
    e.bcout = b1;
    e.m = {18'd0, a} * {18'd0, b1};
    case (op[1:0])
      2'b01:   x = {12'd0, e.m};
      2'b11:   x = {d[11:0], a, b1};
      default: x = '0;
    endcase
    case (op[3:2])
      2'b01:   z = pcin;
      2'b11:   z = c;
      default: z = '0;
    endcase
    if (op[7]) s = {1'b0, z} - ({1'b0, x} + {48'd0, op[5]});
    else       s = {1'b0, z} + ({1'b0, x} + {48'd0, op[5]});
    e.p  = s[47:0];
    e.co = s[48];
    return e;
  endfunction

  // Pops the oldest expectation and compares the full output set against it.
  task automatic test_full_outputs(input string name);
    exp_t e;
    e = exp_q.pop_front();
    $display("txn %s: BCOUT=%h M=%h P=%h CO=%b", name, BCOUT, M, P, CARRYOUT);
    checks++;
    if ({BCOUT, M, P, CARRYOUT} !== {e.bcout, e.m, e.p, e.co}) begin
      errors++;
      $display("FAIL %s main got %h/%h/%h/%b want %h/%h/%h/%b", name,
               BCOUT, M, P, CARRYOUT, e.bcout, e.m, e.p, e.co);
    end
    checks++;
    if ({PCOUT, CARRYOUTF} !== {e.p, e.co}) begin
      errors++;
      $display("FAIL %s copies got PCOUT=%h CYF=%b want %h/%b", name,
               PCOUT, CARRYOUTF, e.p, e.co);
    end
  endtask

  task automatic test_reset();
    set_ce(1'b1);
    set_rst(1'b1);
    A = 18'($urandom()); B = 18'($urandom()); D = 18'($urandom());
    BCIN = 18'($urandom()); C = 48'({$urandom(), $urandom()});
    PCIN = 48'({$urandom(), $urandom()}); CARRYIN = 1'b1; opmode = 8'($urandom());
    exp_q.push_back('{bcout: 18'd0, m: 36'd0, p: 48'd0, co: 1'b0});
    step(1);
    test_full_outputs("reset");
  endtask

  task automatic test_mult_sub();
    set_rst(1'b0);
    A = 18'd20; B = 18'd10; D = 18'd25; C = 48'd350; PCIN = 48'd0;
    BCIN = 18'd0; CARRYIN = 1'b0; opmode = 8'hDD;
    exp_q.push_back('{bcout: 18'h00F, m: 36'h12C, p: 48'h32, co: 1'b0});
    step(3);
    // Edge 3: M is final, P still holds C - 20*10 from the unsubtracted B1.
    $display("txn mult_sub_edge3: M=%h P=%h", M, P);
    checks++;
    if (M !== 36'h12C) begin
      errors++;
      $display("FAIL mult_sub_m_latency got %h want %h", M, 36'h12C);
    end
    checks++;
    if (P !== 48'd150) begin
      errors++;
      $display("FAIL mult_sub_p_latency got %h want %h", P, 48'd150);
    end
    step(1);
    test_full_outputs("mult_sub");
  endtask

  task automatic test_preadd();
    opmode = 8'h10;
    exp_q.push_back('{bcout: 18'h023, m: 36'h2BC, p: 48'h0, co: 1'b0});
    step(3);
    test_full_outputs("preadd");
  endtask

  task automatic test_feedback();
    opmode = 8'h0A;
    exp_q.push_back('{bcout: 18'h00A, m: 36'hC8, p: 48'h0, co: 1'b0});
    step(3);
    test_full_outputs("p_feedback");
  endtask

  task automatic test_concat();
    opmode = 8'hA7; A = 18'd5; B = 18'd6; D = 18'd25; C = 48'd350; PCIN = 48'd3000;
    exp_q.push_back('{bcout: 18'd6, m: 36'h1E, p: 48'hFE6FFFEC0BB1, co: 1'b1});
    step(3);
    test_full_outputs("concat_borrow");
  endtask

  task automatic test_cep_hold();
    CEP = 1'b0;
    opmode = 8'h0C; C = 48'd12345; PCIN = 48'd1;
    step(3);
    $display("txn cep_hold: P=%h PCOUT=%h", P, PCOUT);
    checks++;
    if ({P, PCOUT} !== {48'hFE6FFFEC0BB1, 48'hFE6FFFEC0BB1}) begin
      errors++;
      $display("FAIL cep_hold got P=%h PCOUT=%h want %h", P, PCOUT, 48'hFE6FFFEC0BB1);
    end
    RSTP = 1'b1;
    step(1);
    $display("txn rstp_over_cep: P=%h PCOUT=%h", P, PCOUT);
    checks++;
    if ({P, PCOUT} !== 96'd0) begin
      errors++;
      $display("FAIL rstp_over_cep got P=%h PCOUT=%h want 0", P, PCOUT);
    end
    RSTP = 1'b0;
    CEP = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] op;
    for (int i = 0; i < 8; i++) begin
      op = 8'($urandom());
      if (op[1:0] == 2'b10) op[1:0] = 2'b11;
      if (op[3:2] == 2'b10) op[3:2] = 2'b01;
      opmode = op;
      A = 18'($urandom()); B = 18'($urandom()); D = 18'($urandom());
      C = 48'({$urandom(), $urandom()}); PCIN = 48'({$urandom(), $urandom()});
      exp_q.push_back(model(op, A, B, D, C, PCIN));
      step(5);
      test_full_outputs($sformatf("random%0d_op%02h", i, op));
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    opmode = 8'h04;
    step(2);
    for (int i = 0; i < 6; i++) begin
      PCIN = 48'({$urandom(), $urandom()});
      exp_q.push_back('{bcout: 18'd0, m: 36'd0, p: PCIN, co: 1'b0});
      step(1);
      e = exp_q.pop_front();
      $display("txn pcin_stream%0d: P=%h", i, P);
      checks++;
      if (P !== e.p) begin
        errors++;
        $display("FAIL pcin_stream%0d got %h want %h", i, P, e.p);
      end
    end
    opmode = 8'h0C;
    step(1);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        C = 48'({$urandom(), $urandom()});
        exp_q.push_back('{bcout: 18'd0, m: 36'd0, p: C, co: 1'b0});
      end
      step(1);
      if (i >= 1) begin
        e = exp_q.pop_front();
        $display("txn c_stream%0d: P=%h", i, P);
        checks++;
        if (P !== e.p) begin
          errors++;
          $display("FAIL c_stream%0d got %h want %h", i, P, e.p);
        end
      end
    end
  endtask

  initial begin
    set_rst(1'b1);
    set_ce(1'b1);
    A = '0; B = '0; D = '0; C = '0; BCIN = '0; PCIN = '0;
    CARRYIN = 1'b0; opmode = '0;
    step(2);
    test_reset();
    test_mult_sub();
    test_preadd();
    test_feedback();
    test_concat();
    test_cep_hold();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
